// File: rtl/eth_idma_reg_responder_if.sv
// Register bus between the SoC initiator and the Ethernet/iDMA register
// target. The initiator drives addr/write/wdata/wstrb/valid and holds them
// stable until it sees ready. The target returns rdata/error, which are
// only meaningful while ready is high.
//   master : initiator side (drives the request, samples the response)
//   slave  : target side (samples the request, drives the response)
interface eth_idma_reg_responder_if;
  logic [31:0] addr;
  logic        write;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        valid;
  logic [31:0] rdata;
  logic        error;
  logic        ready;

  modport master (output addr, write, wdata, wstrb, valid,
                  input  rdata, error, ready);
  modport slave  (input  addr, write, wdata, wstrb, valid,
                  output rdata, error, ready);
endinterface

// File: rtl/eth_idma_reg_responder.sv
// Register target holding the Ethernet MAC address/frame configuration and
// a single iDMA transfer descriptor. Software programs the descriptor, sets
// REQ_VALID to launch it, and collects response status and a completion count.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   reg_bus                 32-bit register bus (slave side)
//   mac_addr_o, eth_cfg_o   MAC address and frame configuration
//   idma_req_*              descriptor valid/ready handshake
//   src/dst_addr_o, length_o, src/dst_protocol_o  descriptor fields
//   idma_rsp_*              transfer response handshake and error flag
module eth_idma_reg_responder #(
  parameter int AddrWidth  = 64,
  parameter int TFLenWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  eth_idma_reg_responder_if.slave reg_bus,
  output logic [47:0]           mac_addr_o,
  output logic [15:0]           eth_cfg_o,
  output logic                  idma_req_valid_o,
  input  logic                  idma_req_ready_i,
  output logic [AddrWidth-1:0]  src_addr_o,
  output logic [AddrWidth-1:0]  dst_addr_o,
  output logic [TFLenWidth-1:0] length_o,
  output logic [2:0]            src_protocol_o,
  output logic [2:0]            dst_protocol_o,
  input  logic                  idma_rsp_valid_i,
  input  logic                  idma_rsp_error_i,
  output logic                  idma_rsp_ready_o
);

  // Bits of the HI address words and LENGTH that exist in hardware; the
  // rest are never stored, so they read back as zero.
  localparam logic [63:0] ADDR_MASK = (AddrWidth >= 64) ? {64{1'b1}} :
                                      ((64'd1 << AddrWidth) - 64'd1);
  localparam logic [31:0] HI_MASK   = ADDR_MASK[63:32];
  localparam logic [31:0] LEN_MASK  = (TFLenWidth >= 32) ? {32{1'b1}} :
                                      ((32'd1 << TFLenWidth) - 32'd1);

  typedef enum logic {IDLE, ACK} state_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] addr_p0, wdata_p0;
  logic [3:0]  wstrb_p0;
  logic        we_p0;

  logic [31:0] mac_lo_q, mac_hi_q, src_lo_q, dst_lo_q, src_hi_q, dst_hi_q, len_q;
  logic [2:0]  src_proto_q, dst_proto_q;
  logic        req_valid_q, rsp_ready_q, status_err_q, status_seen_q;
  logic [15:0] done_cnt_q;

  logic [4:0]  idx;
  logic [31:0] rd_val;
  logic        dec_err, is_ro, is_desc, acc_err;
  logic        in_ack, commit_wr, rd_status, req_hs, rsp_hs;
  logic [63:0] src_full, dst_full;

  // Stage p0: capture the access so the response never depends on reg_req.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && reg_bus.valid) begin
      addr_p0  <= reg_bus.addr;
      we_p0    <= reg_bus.write;
      wdata_p0 <= reg_bus.wdata;
      wstrb_p0 <= reg_bus.wstrb;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    reg_bus.ready = 1'b0;
    reg_bus.error = 1'b0;
    reg_bus.rdata = '0;
    case (state_q)
      IDLE: if (reg_bus.valid) state_d = ACK;
      ACK: begin
        state_d = IDLE;
        // An access interrupted by reset is never acknowledged.
        if (!rst_i) begin
          reg_bus.ready = 1'b1;
          reg_bus.error = acc_err;
          reg_bus.rdata = (we_p0 || acc_err) ? '0 : rd_val;
        end
      end
    endcase
  end

  assign idx = addr_p0[6:2];

  always_comb begin
    rd_val  = '0;
    dec_err = 1'b0;
    is_ro   = 1'b0;
    is_desc = 1'b0;
    case (idx)
      5'd0:  rd_val = mac_lo_q;
      5'd1:  rd_val = mac_hi_q;
      5'd4:  begin rd_val = src_lo_q;               is_desc = 1'b1; end
      5'd5:  begin rd_val = dst_lo_q;               is_desc = 1'b1; end
      5'd6:  begin rd_val = len_q;                  is_desc = 1'b1; end
      5'd7:  begin rd_val = {29'd0, src_proto_q};   is_desc = 1'b1; end
      5'd8:  begin rd_val = {29'd0, dst_proto_q};   is_desc = 1'b1; end
      5'd9:  begin rd_val = src_hi_q;               is_desc = 1'b1; end
      5'd10: begin rd_val = dst_hi_q;               is_desc = 1'b1; end
      5'd14: rd_val = {31'd0, req_valid_q};
      5'd15: begin rd_val = {31'd0, idma_req_ready_i}; is_ro = 1'b1; end
      5'd16: rd_val = {31'd0, rsp_ready_q};
      5'd17: begin rd_val = {30'd0, status_seen_q, status_err_q}; is_ro = 1'b1; end
      5'd18: begin rd_val = {16'd0, done_cnt_q}; is_ro = 1'b1; end
      default: dec_err = 1'b1;
    endcase
    // Only word-aligned offsets inside the 128-byte window decode.
    if (addr_p0[31:7] != '0 || addr_p0[1:0] != 2'b00) dec_err = 1'b1;
    // The descriptor is frozen while a request is outstanding.
    acc_err = dec_err | (we_p0 & is_ro) | (we_p0 & is_desc & req_valid_q);
  end

  assign in_ack    = (state_q == ACK);
  assign commit_wr = in_ack & we_p0 & ~acc_err;
  assign rd_status = in_ack & ~we_p0 & ~acc_err & (idx == 5'd17);
  assign req_hs    = req_valid_q & idma_req_ready_i;
  assign rsp_hs    = idma_rsp_valid_i & rsp_ready_q;

  // Stage p1: commit; values reach the outputs the cycle after ACK.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mac_lo_q      <= '0;
      mac_hi_q      <= '0;
      src_lo_q      <= '0;
      dst_lo_q      <= '0;
      src_hi_q      <= '0;
      dst_hi_q      <= '0;
      len_q         <= '0;
      src_proto_q   <= '0;
      dst_proto_q   <= '0;
      req_valid_q   <= 1'b0;
      rsp_ready_q   <= 1'b0;
      status_err_q  <= 1'b0;
      status_seen_q <= 1'b0;
      done_cnt_q    <= '0;
    end else begin
      if (req_hs) req_valid_q <= 1'b0;
      // A new response outranks the read-clear of the sticky bit.
      if (rd_status) status_seen_q <= 1'b0;
      if (rsp_hs) begin
        status_err_q  <= idma_rsp_error_i;
        status_seen_q <= 1'b1;
        done_cnt_q    <= done_cnt_q + 16'd1;
      end
      // Placed after the handshake clear so a concurrent REQ_VALID write wins.
      if (commit_wr) begin
        case (idx)
          5'd0:  mac_lo_q <= apply_strb(mac_lo_q, wdata_p0, wstrb_p0);
          5'd1:  mac_hi_q <= apply_strb(mac_hi_q, wdata_p0, wstrb_p0);
          5'd4:  src_lo_q <= apply_strb(src_lo_q, wdata_p0, wstrb_p0);
          5'd5:  dst_lo_q <= apply_strb(dst_lo_q, wdata_p0, wstrb_p0);
          5'd6:  len_q    <= apply_strb(len_q, wdata_p0, wstrb_p0) & LEN_MASK;
          5'd7:  if (wstrb_p0[0]) src_proto_q <= wdata_p0[2:0];
          5'd8:  if (wstrb_p0[0]) dst_proto_q <= wdata_p0[2:0];
          5'd9:  src_hi_q <= apply_strb(src_hi_q, wdata_p0, wstrb_p0) & HI_MASK;
          5'd10: dst_hi_q <= apply_strb(dst_hi_q, wdata_p0, wstrb_p0) & HI_MASK;
          5'd14: if (wstrb_p0[0]) req_valid_q <= wdata_p0[0];
          5'd16: if (wstrb_p0[0]) rsp_ready_q <= wdata_p0[0];
          default: ;
        endcase
      end
    end
  end

  assign src_full         = {src_hi_q, src_lo_q};
  assign dst_full         = {dst_hi_q, dst_lo_q};
  assign mac_addr_o       = {mac_hi_q[15:0], mac_lo_q};
  assign eth_cfg_o        = mac_hi_q[31:16];
  assign idma_req_valid_o = req_valid_q;
  assign src_addr_o       = src_full[AddrWidth-1:0];
  assign dst_addr_o       = dst_full[AddrWidth-1:0];
  assign length_o         = len_q[TFLenWidth-1:0];
  assign src_protocol_o   = src_proto_q;
  assign dst_protocol_o   = dst_proto_q;
  assign idma_rsp_ready_o = rsp_ready_q;

endmodule

// File: tb/tb_eth_idma_reg_responder.sv
module tb_eth_idma_reg_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] mac_addr;
  logic [15:0] eth_cfg;
  logic        req_valid, req_ready = 1'b0;
  logic [63:0] src_addr, dst_addr;
  logic [31:0] length;
  logic [2:0]  src_proto, dst_proto;
  logic        rsp_valid = 1'b0, rsp_error = 1'b0, rsp_ready;

  int errors = 0;
  int checks = 0;

  eth_idma_reg_responder_if bus ();

  eth_idma_reg_responder #(.AddrWidth(64), .TFLenWidth(32)) dut (
    .clk_i(clk), .rst_i(rst), .reg_bus(bus),
    .mac_addr_o(mac_addr), .eth_cfg_o(eth_cfg),
    .idma_req_valid_o(req_valid), .idma_req_ready_i(req_ready),
    .src_addr_o(src_addr), .dst_addr_o(dst_addr), .length_o(length),
    .src_protocol_o(src_proto), .dst_protocol_o(dst_proto),
    .idma_rsp_valid_i(rsp_valid), .idma_rsp_error_i(rsp_error),
    .idma_rsp_ready_o(rsp_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [31:0] a, input logic w,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic [31:0] r, input logic e);
    vec_t v;
    v.addr = a; v.wr = w; v.wdata = d; v.strb = s; v.rd = r; v.err = e;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Full access: ready is awaited with a bound, then one extra cycle lets
  // the commit land so register outputs can be checked right after.
  task automatic acc(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd,
                     output logic er, output int lat);
    bus.addr = a; bus.write = w; bus.wdata = d; bus.wstrb = s; bus.valid = 1'b1;
    lat = 0; rd = '0; er = 1'b0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (bus.ready) begin
        rd = bus.rdata; er = bus.error;
        break;
      end
      if (lat >= 8) begin
        errors++; checks++;
        $display("FAIL ready timeout addr=0x%0h got no ready expected ready", a);
        break;
      end
    end
    bus.valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a,
                        input logic [31:0] exp, input logic exp_err);
    logic [31:0] r; logic e; int l;
    acc(a, 1'b0, 32'd0, 4'h0, r, e, l);
    chk({nm, " rdata"}, r, exp);
    chk({nm, " error"}, e, exp_err);
  endtask

  task automatic wr_chk(input string nm, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic exp_err);
    logic [31:0] r; logic e; int l;
    acc(a, 1'b1, d, s, r, e, l);
    chk({nm, " error"}, e, exp_err);
  endtask

  // Access whose ACK cycle coincides with an iDMA event driven by the caller.
  task automatic ack_with_event(input logic [31:0] a, input logic w, input logic [31:0] d,
                                input logic set_req_ready, input logic set_rsp_valid,
                                input logic set_rsp_err, output logic [31:0] rd);
    bus.addr = a; bus.write = w; bus.wdata = d; bus.wstrb = 4'hF; bus.valid = 1'b1;
    @(posedge clk); #1;
    chk("event ack ready", bus.ready, 1'b1);
    rd = bus.rdata;
    bus.valid = 1'b0;
    req_ready = set_req_ready; rsp_valid = set_rsp_valid; rsp_error = set_rsp_err;
    @(posedge clk); #1;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_error = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          l;

    bus.addr = '0; bus.write = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.valid = 1'b0;

    // Post-reset reads, MAC programming, descriptor programming, bad offsets.
    add(32'h00, 0, 0, 0, 32'h0, 0);  add(32'h04, 0, 0, 0, 32'h0, 0);
    add(32'h10, 0, 0, 0, 32'h0, 0);  add(32'h14, 0, 0, 0, 32'h0, 0);
    add(32'h18, 0, 0, 0, 32'h0, 0);  add(32'h1C, 0, 0, 0, 32'h0, 0);
    add(32'h20, 0, 0, 0, 32'h0, 0);  add(32'h24, 0, 0, 0, 32'h0, 0);
    add(32'h28, 0, 0, 0, 32'h0, 0);  add(32'h38, 0, 0, 0, 32'h0, 0);
    add(32'h40, 0, 0, 0, 32'h0, 0);  add(32'h44, 0, 0, 0, 32'h0, 0);
    add(32'h48, 0, 0, 0, 32'h0, 0);  add(32'h3C, 0, 0, 0, 32'h0, 0);
    add(32'h30, 0, 0, 0, 32'h0, 1);
    add(32'h00, 1, 32'h98001032, 4'hF, 32'h0, 0);
    add(32'h04, 1, 32'h00002070, 4'hF, 32'h0, 0);
    add(32'h00, 0, 0, 0, 32'h98001032, 0);
    add(32'h04, 0, 0, 0, 32'h00002070, 0);
    add(32'h10, 1, 32'h0, 4'hF, 32'h0, 0);
    add(32'h14, 1, 32'h0, 4'hF, 32'h0, 0);
    add(32'h18, 1, 32'h40, 4'hF, 32'h0, 0);
    add(32'h1C, 1, 32'h0, 4'hF, 32'h0, 0);
    add(32'h20, 1, 32'hFFFFFFFD, 4'hF, 32'h0, 0);
    add(32'h20, 0, 0, 0, 32'h5, 0);
    add(32'h18, 0, 0, 0, 32'h40, 0);
    add(32'h28, 1, 32'hA5A5A5A5, 4'hF, 32'h0, 0);
    add(32'h28, 0, 0, 0, 32'hA5A5A5A5, 0);
    add(32'h28, 1, 32'h0, 4'hF, 32'h0, 0);
    add(32'h3C, 1, 32'h1, 4'hF, 32'h0, 1);
    add(32'h44, 1, 32'h3, 4'hF, 32'h0, 1);
    add(32'h48, 1, 32'h7, 4'hF, 32'h0, 1);
    add(32'h4C, 0, 0, 0, 32'h0, 1);
    add(32'h02, 0, 0, 0, 32'h0, 1);
    add(32'h100, 0, 0, 0, 32'h0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset rsp ready", bus.ready, 1'b0);
    chk("reset rsp error", bus.error, 1'b0);
    chk("reset rsp rdata", bus.rdata, 32'h0);
    chk("reset req valid", req_valid, 1'b0);
    chk("reset rsp_ready_o", rsp_ready, 1'b0);
    chk("reset mac", mac_addr, 48'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      acc(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].strb, r, e, l);
      chk($sformatf("vec%0d rdata", i), r, vecs[i].rd);
      chk($sformatf("vec%0d error", i), e, vecs[i].err);
      chk($sformatf("vec%0d latency", i), l, 1);
    end

    chk("mac_addr_o", mac_addr, 48'h207098001032);
    chk("eth_cfg_o", eth_cfg, 16'h0000);
    chk("length_o", length, 32'h40);
    chk("src_proto", src_proto, 3'd0);
    chk("dst_proto", dst_proto, 3'd5);
    chk("src_addr", src_addr, 64'h0);
    chk("dst_addr", dst_addr, 64'h0);

    // Request held while iDMA stalls; descriptor locked.
    wr_chk("req set", 32'h38, 32'h1, 4'hF, 1'b0);
    chk("req valid up", req_valid, 1'b1);
    wr_chk("locked len write", 32'h18, 32'h80, 4'hF, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("req valid held", req_valid, 1'b1);
    chk("length locked", length, 32'h40);
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    chk("req valid dropped", req_valid, 1'b0);
    rd_chk("req reg cleared", 32'h38, 32'h0, 1'b0);

    // Byte strobes.
    wr_chk("len strb0", 32'h18, 32'h000000FF, 4'h1, 1'b0);
    rd_chk("len after strb0", 32'h18, 32'h000000FF, 1'b0);
    wr_chk("len strb1", 32'h18, 32'h00001200, 4'h2, 1'b0);
    rd_chk("len after strb1", 32'h18, 32'h000012FF, 1'b0);

    // Withdraw and live ready readback.
    wr_chk("req set2", 32'h38, 32'h1, 4'hF, 1'b0);
    wr_chk("req withdraw", 32'h38, 32'h0, 4'hF, 1'b0);
    chk("req withdrawn", req_valid, 1'b0);
    req_ready = 1'b1;
    rd_chk("req_ready live", 32'h3C, 32'h1, 1'b0);
    req_ready = 1'b0;

    // Response with error.
    wr_chk("rsp ready set", 32'h40, 32'h1, 4'hF, 1'b0);
    chk("rsp_ready_o", rsp_ready, 1'b1);
    rsp_valid = 1'b1; rsp_error = 1'b1;
    @(posedge clk); #1;
    rsp_valid = 1'b0; rsp_error = 1'b0;
    rd_chk("status first", 32'h44, 32'h3, 1'b0);
    rd_chk("done cnt 1", 32'h48, 32'h1, 1'b0);
    rd_chk("status cleared", 32'h44, 32'h1, 1'b0);

    // REQ_VALID rewrite coinciding with a handshake keeps the request.
    wr_chk("req set3", 32'h38, 32'h1, 4'hF, 1'b0);
    ack_with_event(32'h38, 1'b1, 32'h1, 1'b1, 1'b0, 1'b0, r);
    chk("req rewrite wins", req_valid, 1'b1);
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    chk("req cleared after", req_valid, 1'b0);

    // Count wrap: 65534 more responses reach 0xFFFF, one more wraps.
    rsp_valid = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    rsp_valid = 1'b0;
    rd_chk("done cnt ffff", 32'h48, 32'hFFFF, 1'b0);
    rsp_valid = 1'b1;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    rd_chk("done cnt wrap", 32'h48, 32'h0, 1'b0);
    rd_chk("status no err", 32'h44, 32'h2, 1'b0);

    // DONE_CNT read while it increments returns the old value.
    ack_with_event(32'h48, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, r);
    chk("done cnt pre-inc", r, 32'h0);
    rd_chk("done cnt post", 32'h48, 32'h1, 1'b0);

    // STATUS read while a new response lands keeps the sticky bit.
    ack_with_event(32'h44, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, r);
    chk("status concurrent rd", r, 32'h2);
    rd_chk("status sticky kept", 32'h44, 32'h3, 1'b0);
    rd_chk("status after clear", 32'h44, 32'h1, 1'b0);

    // Reset in the middle of an access.
    bus.addr = 32'h00; bus.write = 1'b1; bus.wdata = 32'h12345678; bus.wstrb = 4'hF;
    bus.valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.valid = 1'b0;
    #0;
    chk("ready gated by reset", bus.ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ready after reset", bus.ready, 1'b0);
    chk("mac after reset", mac_addr, 48'h0);
    chk("length after reset", length, 32'h0);
    chk("dst proto after reset", dst_proto, 3'd0);
    chk("rsp_ready_o after reset", rsp_ready, 1'b0);
    @(posedge clk); #1;
    chk("ready idle", bus.ready, 1'b0);
    rd_chk("done cnt after reset", 32'h48, 32'h0, 1'b0);
    rd_chk("mac lo after reset", 32'h00, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
